// File: rtl/picoblaze_io_pkg.sv
// Shared address map and bit positions for the PicoBlaze I/O hub.
package picoblaze_io_pkg;

    localparam logic [7:0] ADDR_IN_BASE  = 8'h00;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h40;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h41;
    localparam logic [7:0] ADDR_IRQ_CLR  = 8'h42;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h80;

    localparam int unsigned TICK_BIT = 7;

    typedef enum logic [1:0] {
        RdNone,
        RdIn,
        RdStat,
        RdMask
    } rd_sel_e;

    // True when id falls in the 8-entry window at base and its index is below n.
    function automatic logic addr_in_window(logic [7:0] id, logic [7:0] base, int unsigned n);
        return (id[7:3] == base[7:3]) && (32'(id[2:0]) < n);
    endfunction

endpackage

// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt controller: edge detect, pending/mask/in-service state and registered interrupt.
// The periodic tick source is built only when PICOBLAZE_TICK_TIMER_EN is defined.
module picoblaze_irq_ctrl
    import picoblaze_io_pkg::*;
#(
    parameter int unsigned NUM_IRQ        = 1,
    parameter int unsigned CLK_FREQ_IN_HZ = 25000000,
    parameter int unsigned TICK_HZ        = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               mask_we_i,
    input  logic               clr_we_i,
    input  logic [7:0]         wdata_i,
    input  logic               irq_ack_i,
    output logic [7:0]         status_o,
    output logic [7:0]         mask_o,
    output logic               irq_o
);

    logic               tick_wrap;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [7:0]         pending_q, pending_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         clr_bits;
    logic               in_service_q, in_service_d;
    logic               irq_q, irq_d;

`ifdef PICOBLAZE_TICK_TIMER_EN
    localparam bit          TickEn  = 1'b1;
    localparam int unsigned TickDiv = (CLK_FREQ_IN_HZ / TICK_HZ > 0) ?
                                      CLK_FREQ_IN_HZ / TICK_HZ : 1;
    localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(TickDiv - 1);

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_wrap  = (tick_cnt_q == TickMax);
        tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end
`else
    localparam bit TickEn = 1'b0;
    assign tick_wrap = 1'b0;
`endif

    // Bits that can ever hold a pending flag; everything else reads as zero.
    localparam logic [7:0] ImplMask = 8'((1 << NUM_IRQ) - 1) | (TickEn ? 8'h80 : 8'h00);

    always_comb begin
        irq_edge  = irq_src_i & ~irq_prev_q;
        clr_bits  = clr_we_i ? wdata_i : 8'h00;
        // Set is OR-ed in after the clear so a same-cycle event survives.
        pending_d = ((pending_q & ~clr_bits) | {tick_wrap, 7'(irq_edge)}) & ImplMask;
        mask_d    = mask_we_i ? wdata_i : mask_q;

        in_service_d = in_service_q;
        if (irq_ack_i) begin
            in_service_d = 1'b1;
        end else if (clr_we_i) begin
            in_service_d = 1'b0;
        end

        irq_d = (|(pending_q & mask_q)) & ~in_service_q & ~irq_ack_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q   <= '0;
            pending_q    <= 8'h00;
            mask_q       <= 8'h00;
            in_service_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            irq_prev_q   <= irq_src_i;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            irq_q        <= irq_d;
        end
    end

    assign status_o = pending_q;
    assign mask_o   = mask_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/picoblaze_io_hub.sv
// PicoBlaze port-mapped I/O hub: address decode, input read mux and output registers.
// Optional tick interrupt source enabled by defining PICOBLAZE_TICK_TIMER_EN.
module picoblaze_io_hub
    import picoblaze_io_pkg::*;
#(
    parameter int unsigned NUM_IN         = 2,
    parameter int unsigned NUM_OUT        = 2,
    parameter int unsigned NUM_IRQ        = 1,
    parameter int unsigned CLK_FREQ_IN_HZ = 25000000,
    parameter int unsigned TICK_HZ        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    input  logic [7:0]           out_port,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [NUM_IN*8-1:0]  input_data,
    input  logic [NUM_IRQ-1:0]   irq_src,
    output logic [NUM_OUT*8-1:0] out_data,
    output logic [NUM_OUT-1:0]   out_wr
);

    logic [7:0]           in_port_q, in_port_d;
    logic [NUM_OUT*8-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]   out_wr_q, out_wr_d;
    logic [7:0]           irq_status, irq_mask;
    logic                 mask_we, clr_we, out_hit;
    rd_sel_e              rd_sel;
    logic                 unused_read_strobe;

    // in_port is refreshed every cycle from port_id alone.
    assign unused_read_strobe = read_strobe;

    always_comb begin
        rd_sel = RdNone;
        if (addr_in_window(port_id, ADDR_IN_BASE, NUM_IN)) begin
            rd_sel = RdIn;
        end else if (port_id == ADDR_IRQ_STAT) begin
            rd_sel = RdStat;
        end else if (port_id == ADDR_IRQ_MASK) begin
            rd_sel = RdMask;
        end

        in_port_d = 8'h00;
        unique case (rd_sel)
            RdIn: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (port_id[2:0] == 3'(i)) begin
                        in_port_d = input_data[i*8 +: 8];
                    end
                end
            end
            RdStat:  in_port_d = irq_status;
            RdMask:  in_port_d = irq_mask;
            default: in_port_d = 8'h00;
        endcase

        out_hit    = write_strobe && addr_in_window(port_id, ADDR_OUT_BASE, NUM_OUT);
        out_data_d = out_data_q;
        out_wr_d   = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_hit && (port_id[2:0] == 3'(i))) begin
                out_data_d[i*8 +: 8] = out_port;
                out_wr_d[i]          = 1'b1;
            end
        end

        mask_we = write_strobe && (port_id == ADDR_IRQ_MASK);
        clr_we  = write_strobe && (port_id == ADDR_IRQ_CLR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port_q  <= 8'h00;
            out_data_q <= '0;
            out_wr_q   <= '0;
        end else begin
            in_port_q  <= in_port_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
        end
    end

    picoblaze_irq_ctrl #(
        .NUM_IRQ       (NUM_IRQ),
        .CLK_FREQ_IN_HZ(CLK_FREQ_IN_HZ),
        .TICK_HZ       (TICK_HZ)
    ) u_irq_ctrl (
        .clk      (clk),
        .reset    (reset),
        .irq_src_i(irq_src),
        .mask_we_i(mask_we),
        .clr_we_i (clr_we),
        .wdata_i  (out_port),
        .irq_ack_i(interrupt_ack),
        .status_o (irq_status),
        .mask_o   (irq_mask),
        .irq_o    (interrupt)
    );

    assign in_port  = in_port_q;
    assign out_data = out_data_q;
    assign out_wr   = out_wr_q;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Scoreboard bench for picoblaze_io_hub: stimulus queues timed expectations, a negedge
// monitor retires them. Honours PICOBLAZE_TICK_TIMER_EN for the tick checks.
module tb_picoblaze_io_hub;

    localparam int unsigned NUM_IN  = 2;
    localparam int unsigned NUM_OUT = 2;
    localparam int unsigned NUM_IRQ = 1;

`ifdef PICOBLAZE_TICK_TIMER_EN
    localparam bit          TickEn  = 1'b1;
    localparam logic [15:0] StatCmp = 16'h007F;
`else
    localparam bit          TickEn  = 1'b0;
    localparam logic [15:0] StatCmp = 16'h00FF;
`endif

    typedef enum logic [1:0] {SigInPort, SigIrq, SigOutData, SigOutWr} sig_e;

    typedef struct {
        int          due;
        sig_e        sel;
        logic [15:0] exp;
        logic [15:0] cmp;
        string       name;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           port_id;
    logic                 write_strobe;
    logic                 read_strobe;
    logic [7:0]           out_port;
    logic [7:0]           in_port;
    logic                 interrupt;
    logic                 interrupt_ack;
    logic [NUM_IN*8-1:0]  input_data;
    logic [NUM_IRQ-1:0]   irq_src;
    logic [NUM_OUT*8-1:0] out_data;
    logic [NUM_OUT-1:0]   out_wr;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   r;

    picoblaze_io_hub #(
        .NUM_IN        (NUM_IN),
        .NUM_OUT       (NUM_OUT),
        .NUM_IRQ       (NUM_IRQ),
        .CLK_FREQ_IN_HZ(10),
        .TICK_HZ       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .input_data   (input_data),
        .irq_src      (irq_src),
        .out_data     (out_data),
        .out_wr       (out_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(sig_e sel);
        case (sel)
            SigInPort:  return {8'h00, in_port};
            SigIrq:     return {15'h0, interrupt};
            SigOutData: return out_data;
            default:    return {14'h0, out_wr};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                act = pick(sb[i].sel);
                n_cmp++;
                if (sb[i].due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation missed its cycle %0d", sb[i].name, sb[i].due);
                end else if ((act & sb[i].cmp) !== (sb[i].exp & sb[i].cmp)) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h, required 0x%04h (cycle %0d)",
                             sb[i].name, act & sb[i].cmp, sb[i].exp & sb[i].cmp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_sig(sig_e sel, int lat, logic [15:0] val, logic [15:0] cmp,
                              string name);
        exp_t e;
        e.due  = cyc + lat;
        e.sel  = sel;
        e.exp  = val;
        e.cmp  = cmp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
    endtask

    task automatic rd(logic [7:0] a, logic [7:0] val, logic [15:0] cmp, string name);
        port_id = a;
        expect_sig(SigInPort, 1, {8'h00, val}, cmp, name);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; interrupt_ack = 1'b0; input_data = '0; irq_src = '0;
        step(); step();
        expect_sig(SigInPort, 0, 16'h0000, 16'hFFFF, "rst_in_port");
        expect_sig(SigIrq, 0, 16'h0000, 16'hFFFF, "rst_irq");
        expect_sig(SigOutData, 0, 16'h0000, 16'hFFFF, "rst_out_data");
        expect_sig(SigOutWr, 0, 16'h0000, 16'hFFFF, "rst_out_wr");
        step();
        reset = 1'b0;

        // Output register write and strobe pulse
        port_id = 8'h81; out_port = 8'hA5; write_strobe = 1'b1;
        expect_sig(SigOutData, 1, 16'hA500, 16'hFFFF, "wr81_data");
        expect_sig(SigOutWr, 1, 16'h0002, 16'hFFFF, "wr81_strobe");
        expect_sig(SigInPort, 1, 16'h0000, 16'hFFFF, "rd81_zero");
        step();
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
        expect_sig(SigOutWr, 1, 16'h0000, 16'hFFFF, "wr_pulse_end");
        expect_sig(SigOutData, 1, 16'hA500, 16'hFFFF, "wr81_hold");
        step();

        // Input reads, unmapped and aliased IDs
        input_data = 16'h773C;
        rd(8'h00, 8'h3C, 16'hFFFF, "rd_in0");
        rd(8'h55, 8'h00, 16'hFFFF, "rd_unmapped");
        rd(8'h01, 8'h77, 16'hFFFF, "rd_in1");
        rd(8'h02, 8'h00, 16'hFFFF, "rd_in_oor");
        rd(8'h08, 8'h00, 16'hFFFF, "rd_in_alias");

        // Writes outside the output window are ignored
        port_id = 8'h82; out_port = 8'hFF; write_strobe = 1'b1;
        expect_sig(SigOutData, 1, 16'hA500, 16'hFFFF, "wr82_ignored");
        expect_sig(SigOutWr, 1, 16'h0000, 16'hFFFF, "wr82_no_strobe");
        step();
        port_id = 8'hC1;
        expect_sig(SigOutData, 1, 16'hA500, 16'hFFFF, "wrC1_ignored");
        expect_sig(SigOutWr, 1, 16'h0000, 16'hFFFF, "wrC1_no_strobe");
        step();
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;

        // Unused mask bits are storable but do not enable source 0
        wr(8'h41, 8'h7E);
        rd(8'h41, 8'h7E, 16'hFFFF, "mask_rd_7e");
        irq_src = 1'b1;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_masked_1");
        expect_sig(SigIrq, 2, 16'h0000, 16'hFFFF, "irq_masked_2");
        step();
        irq_src = 1'b0;
        rd(8'h40, 8'h01, StatCmp, "stat_masked");
        wr(8'h42, 8'h01);
        rd(8'h40, 8'h00, StatCmp, "stat_clr0");

        // Edge -> interrupt, acknowledge, clear
        wr(8'h41, 8'h01);
        rd(8'h41, 8'h01, 16'hFFFF, "mask_rd_01");
        irq_src = 1'b1;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_lat1");
        expect_sig(SigIrq, 2, 16'h0001, 16'hFFFF, "irq_lat2");
        step();
        irq_src = 1'b0;
        step();
        interrupt_ack = 1'b1;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_ack_drop");
        step();
        interrupt_ack = 1'b0;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_in_service");
        step();
        port_id = 8'h42; out_port = 8'h01; write_strobe = 1'b1;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_clr_1");
        expect_sig(SigIrq, 2, 16'h0000, 16'hFFFF, "irq_clr_2");
        step();
        write_strobe = 1'b0; out_port = 8'h00;
        rd(8'h40, 8'h00, StatCmp, "stat_after_clr");

        // Clearing in_service with a pending bit left re-asserts interrupt
        irq_src = 1'b1;
        expect_sig(SigIrq, 2, 16'h0001, 16'hFFFF, "irq_again");
        step();
        irq_src = 1'b0;
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        port_id = 8'h42; out_port = 8'h00; write_strobe = 1'b1;
        expect_sig(SigIrq, 1, 16'h0000, 16'hFFFF, "irq_svc_hold");
        expect_sig(SigIrq, 2, 16'h0001, 16'hFFFF, "irq_reassert");
        step();
        write_strobe = 1'b0;
        expect_sig(SigIrq, 2, 16'h0000, 16'hFFFF, "irq_final_clr");
        wr(8'h42, 8'h01);

        // Same-cycle set and clear: set wins; held level does not re-set
        irq_src = 1'b1;
        port_id = 8'h42; out_port = 8'h01; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; out_port = 8'h00;
        rd(8'h40, 8'h01, StatCmp, "set_wins");
        wr(8'h42, 8'h01);
        rd(8'h40, 8'h00, StatCmp, "held_no_reset_1");
        rd(8'h40, 8'h00, StatCmp, "held_no_reset_2");
        irq_src = 1'b0;
        step();

        // Asynchronous reset while interrupt is high and out_data is nonzero
        irq_src = 1'b1;
        expect_sig(SigIrq, 2, 16'h0001, 16'hFFFF, "irq_pre_reset");
        step();
        irq_src = 1'b0;
        step();
        step();
        reset = 1'b1;
        expect_sig(SigIrq, 0, 16'h0000, 16'hFFFF, "rst_async_irq");
        expect_sig(SigOutData, 0, 16'h0000, 16'hFFFF, "rst_async_data");
        step();
        reset = 1'b0;
        r = cyc;
        rd(8'h41, 8'h00, 16'hFFFF, "rst_mask");

        // Tick source: with a 10-cycle divider the first wrap is seen at r+11
        while (cyc < r + 12) begin
            port_id = 8'h40;
            expect_sig(SigInPort, 1, (TickEn && (cyc + 1 - r >= 11)) ? 16'h0080 : 16'h0000,
                       16'hFFFF, "tick_first");
            step();
        end
        port_id = 8'h42; out_port = 8'h80; write_strobe = 1'b1;
        expect_sig(SigInPort, 1, 16'h0000, 16'hFFFF, "tick_clr_rd");
        step();
        write_strobe = 1'b0; out_port = 8'h00;
        while (cyc < r + 24) begin
            port_id = 8'h40;
            expect_sig(SigInPort, 1, (TickEn && (cyc + 1 - r >= 21)) ? 16'h0080 : 16'h0000,
                       16'hFFFF, "tick_second");
            step();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
